// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, counter type and generator state type.
// Pixel generators import this package so they agree with the timing generator.
package vga_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // ST_PRIME holds (0,0) for the first enabled edge after reset so the origin is shown once.
  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } vga_state_e;

  function automatic logic in_window(cnt_t value, cnt_t first, cnt_t last);
    return (value >= first) && (value <= last);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle between the VGA timing generator (master) and its pixel consumers (slave).
interface vga_timing_if;
  import vga_pkg::*;

  logic ce;
  logic hsync;
  logic vsync;
  logic display_on;
  cnt_t hpos;
  cnt_t vpos;
  logic line_start;
  logic frame_start;

  modport master (
    input  ce,
    output hsync, vsync, display_on, hpos, vpos, line_start, frame_start
  );

  modport slave (
    output ce,
    input  hsync, vsync, display_on, hpos, vpos, line_start, frame_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blanking and
// start-of-line/frame strobes that are aligned with the counters they describe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.master vga
);

  localparam int   H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_DISPLAY);
  localparam cnt_t V_VIS    = cnt_t'(V_DISPLAY);
  localparam cnt_t HS_FIRST = cnt_t'(H_DISPLAY + H_FRONT);
  localparam cnt_t HS_LAST  = cnt_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_DISPLAY + V_FRONT);
  localparam cnt_t VS_LAST  = cnt_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  vga_state_e state_q, state_d;
  cnt_t       hpos_q, hpos_d;
  cnt_t       vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_q, disp_d;
  logic       line_q, line_d;
  logic       frame_q, frame_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PRIME;
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      disp_q  <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  // Sync/blank flags decode the next counter value so they land in the same cycle as it.
  always_comb begin
    state_d = state_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    disp_d  = disp_q;
    line_d  = 1'b0;
    frame_d = 1'b0;

    if (vga.ce) begin
      if (state_q == ST_PRIME) begin
        state_d = ST_RUN;
        line_d  = 1'b1;
        frame_d = 1'b1;
      end else if (hpos_q == H_LAST) begin
        hpos_d = '0;
        line_d = 1'b1;
        if (vpos_q == V_LAST) begin
          vpos_d  = '0;
          frame_d = 1'b1;
        end else begin
          vpos_d = vpos_q + cnt_t'(1);
        end
      end else begin
        hpos_d = hpos_q + cnt_t'(1);
      end

      hsync_d = !in_window(hpos_d, HS_FIRST, HS_LAST);
      vsync_d = !in_window(vpos_d, VS_FIRST, VS_LAST);
      disp_d  = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    end
  end

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.display_on  = disp_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size 800x525 instance for line-level and
// reset behaviour, and a 30x20 instance for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  int   tests_run = 0;
  int   fail_count = 0;

  vga_timing_if vd ();
  vga_timing_if vs ();

  vga_timing_gen dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vd)
  );

  // Reduced geometry: H 16/4/6/4 (total 30, hsync low 20..25), V 12/3/2/3 (total 20, vsync low 15..16).
  vga_timing_gen #(
    .H_DISPLAY (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (4),
    .V_DISPLAY (12), .V_FRONT (3), .V_SYNC (2), .V_BACK (3)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int range_err_d = 0, range_err_s = 0, pulse_err_d = 0, pulse_err_s = 0;
  logic prev_line_d = 1'b0, prev_frame_d = 1'b0, prev_line_s = 1'b0, prev_frame_s = 1'b0;

  always @(negedge clk) begin
    if (vd.hpos >= 10'd800 || vd.vpos >= 10'd525) range_err_d++;
    if (vs.hpos >= 10'd30 || vs.vpos >= 10'd20) range_err_s++;
    if ((vd.line_start && prev_line_d) || (vd.frame_start && prev_frame_d)) pulse_err_d++;
    if ((vs.line_start && prev_line_s) || (vs.frame_start && prev_frame_s)) pulse_err_s++;
    prev_line_d  = vd.line_start;
    prev_frame_d = vd.frame_start;
    prev_line_s  = vs.line_start;
    prev_frame_s = vs.frame_start;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ce_d, input logic ce_s, input int cycles);
    vd.ce = ce_d;
    vs.ce = ce_s;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_hpos"}, int'(vd.hpos), 0);
    checkOutput({tag, "_vpos"}, int'(vd.vpos), 0);
    checkOutput({tag, "_hsync"}, int'(vd.hsync), 1);
    checkOutput({tag, "_vsync"}, int'(vd.vsync), 1);
    checkOutput({tag, "_display_on"}, int'(vd.display_on), 0);
    checkOutput({tag, "_line_start"}, int'(vd.line_start), 0);
    checkOutput({tag, "_frame_start"}, int'(vd.frame_start), 0);
  endtask

  int hs_low, hs_first, disp_cnt, line_cnt, model_err, guard;
  int vs_low, vs_first, vs_last, disp_s, disp_blank, frame_n;
  int frame_at [3];
  logic exp_hs, exp_vs, exp_disp;

  initial begin
    rst_n = 1'b1;
    vd.ce = 1'b0;
    vs.ce = 1'b0;
    #1 rst_n = 1'b0;
    #2 checkResetValues("async_reset");

    applyStimulus(1'b0, 1'b0, 2);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1);
    checkResetValues("hold_before_ce");

    // First enabled edge: origin shown, both strobes fire, counters stay at (0,0)
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("prime_hpos", int'(vd.hpos), 0);
    checkOutput("prime_vpos", int'(vd.vpos), 0);
    checkOutput("prime_display_on", int'(vd.display_on), 1);
    checkOutput("prime_line_start", int'(vd.line_start), 1);
    checkOutput("prime_frame_start", int'(vd.frame_start), 1);

    // Scan line 0 sample by sample against a window model
    hs_low = 0; hs_first = -1; disp_cnt = 0; line_cnt = 0; model_err = 0;
    for (int i = 0; i < 800; i++) begin
      exp_hs   = !(vd.hpos >= 10'd656 && vd.hpos <= 10'd751);
      exp_disp = (vd.hpos < 10'd640) && (vd.vpos < 10'd480);
      if (vd.hpos !== 10'(i) || vd.hsync !== exp_hs || vd.display_on !== exp_disp) model_err++;
      if (!vd.hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(vd.hpos);
      end
      if (vd.display_on) disp_cnt++;
      if (vd.line_start) line_cnt++;
      tick();
    end
    checkOutput("line_model_err", model_err, 0);
    checkOutput("line_hsync_low_clks", hs_low, 96);
    checkOutput("line_hsync_first_hpos", hs_first, 656);
    checkOutput("line_display_clks", disp_cnt, 640);
    checkOutput("line_start_in_line", line_cnt, 1);
    checkOutput("wrap_hpos", int'(vd.hpos), 0);
    checkOutput("wrap_vpos", int'(vd.vpos), 1);
    checkOutput("wrap_line_start", int'(vd.line_start), 1);
    checkOutput("wrap_frame_start", int'(vd.frame_start), 0);

    guard = 0;
    while (vd.hpos != 10'd700 && guard < 1000) begin
      tick();
      guard++;
    end
    checkOutput("reach_hpos700", int'(vd.hpos), 700);
    checkOutput("hsync_low_at_700", int'(vd.hsync), 0);

    // Mid-line reset must take effect before the next clock edge
    #2 rst_n = 1'b0;
    #1 checkResetValues("midframe_reset");
    applyStimulus(1'b0, 1'b0, 2);
    rst_n = 1'b1;

    line_cnt = 0; frame_n = 0; model_err = 0;
    vs_low = 0; vs_first = -1; vs_last = -1; disp_s = 0; disp_blank = 0;
    vs.ce = 1'b1;
    for (int k = 1; k <= 1250; k++) begin
      tick();
      exp_hs   = !(vs.hpos >= 10'd20 && vs.hpos <= 10'd25);
      exp_vs   = !(vs.vpos >= 10'd15 && vs.vpos <= 10'd16);
      exp_disp = (vs.hpos < 10'd16) && (vs.vpos < 10'd12);
      if (vs.hsync !== exp_hs || vs.vsync !== exp_vs || vs.display_on !== exp_disp) model_err++;
      if (vs.frame_start) begin
        if (frame_n < 3) frame_at[frame_n] = k;
        frame_n++;
      end
      if (k <= 600) begin
        if (vs.line_start) line_cnt++;
        if (!vs.vsync) begin
          vs_low++;
          if (vs_first < 0) vs_first = int'(vs.vpos);
          vs_last = int'(vs.vpos);
        end
        if (vs.display_on) disp_s++;
        if (vs.display_on && vs.vpos >= 10'd12) disp_blank++;
      end
    end
    checkOutput("frame_model_err", model_err, 0);
    checkOutput("frame_line_starts", line_cnt, 20);
    checkOutput("frame_start_count", frame_n, 3);
    checkOutput("frame_first_at", frame_at[0], 1);
    checkOutput("frame_period_1", frame_at[1] - frame_at[0], 600);
    checkOutput("frame_period_2", frame_at[2] - frame_at[1], 600);
    checkOutput("vsync_low_clks", vs_low, 60);
    checkOutput("vsync_first_vpos", vs_first, 15);
    checkOutput("vsync_last_vpos", vs_last, 16);
    checkOutput("display_clks_frame", disp_s, 192);
    checkOutput("display_in_vblank", disp_blank, 0);

    guard = 0;
    while (!(vs.hpos == 10'd29 && vs.vpos == 10'd19) && guard < 700) begin
      tick();
      guard++;
    end
    checkOutput("reach_last_pixel", int'(vs.hpos) * 100 + int'(vs.vpos), 2919);

    // Alternate ce across the frame wrap
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("ce0_hold_hpos", int'(vs.hpos), 29);
    checkOutput("ce0_hold_vpos", int'(vs.vpos), 19);
    checkOutput("ce0_hold_sync", int'({vs.hsync, vs.vsync, vs.display_on}), 6);
    checkOutput("ce0_no_frame", int'(vs.frame_start), 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("ce1_wrap_pos", int'(vs.hpos) * 100 + int'(vs.vpos), 0);
    checkOutput("ce1_wrap_strobes", int'({vs.frame_start, vs.line_start}), 3);
    checkOutput("ce1_wrap_display", int'(vs.display_on), 1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("ce0_after_pos", int'(vs.hpos) * 100 + int'(vs.vpos), 0);
    checkOutput("ce0_after_strobes", int'({vs.frame_start, vs.line_start}), 0);
    checkOutput("ce0_after_display", int'(vs.display_on), 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("ce1_advance_hpos", int'(vs.hpos), 1);
    checkOutput("ce1_advance_frame", int'(vs.frame_start), 0);
    applyStimulus(1'b0, 1'b0, 2);

    checkOutput("range_full", range_err_d, 0);
    checkOutput("range_small", range_err_s, 0);
    checkOutput("pulse_width_full", pulse_err_d, 0);
    checkOutput("pulse_width_small", pulse_err_s, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
